// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  localparam logic [31:0] MEM_ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // On a tie the master that did not finish last wins.
  function automatic logic pick_winner(input logic v0, input logic v1, input logic last_grant);
    if (v0 && v1) begin
      return ~last_grant;
    end else if (v1) begin
      return GRANT_M1;
    end
    return GRANT_M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// PicoRV32 native memory handshake bundle.
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             instr;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       wstrb;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle watchdog; expire is high on the TIMEOUT-th cycle that run is held.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  assign expire = run && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the RAM driver.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic          grant,
  output logic          timeout_err
);

  arb_state_e state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic       s_valid_q;

  logic             busy;
  logic             gnt_valid;
  logic             expire;
  logic             done;
  logic [WIDTH-1:0] ret_data;

  assign busy      = (state_q == ARB_BUSY);
  assign gnt_valid = (grant_q == GRANT_M1) ? m1.valid : m0.valid;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (!busy && (m0.valid || m1.valid)),
    .run   (busy && !s.ready),
    .expire(expire)
  );
  assign ret_data = expire ? WIDTH'(MEM_ARB_TIMEOUT_RDATA) : s.rdata;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expire         = 1'b0;
  assign ret_data       = s.rdata;
`endif

  // s_ready has priority over watchdog expiry since run excludes it.
  assign done        = busy && (s.ready || expire);
  assign timeout_err = expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= GRANT_M0;
      last_grant_q <= GRANT_M1;
      s_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0.valid || m1.valid) begin
            grant_q   <= pick_winner(m0.valid, m1.valid, last_grant_q);
            state_q   <= ARB_BUSY;
            s_valid_q <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
            s_valid_q    <= 1'b0;
          end else if (!gnt_valid) begin
            state_q   <= ARB_IDLE;
            s_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ARB_IDLE;
          s_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s.valid = s_valid_q;
  assign grant   = grant_q;

  always_comb begin
    s.instr = 1'b0;
    s.addr  = '0;
    s.wdata = '0;
    s.wstrb = '0;
    if (busy) begin
      if (grant_q == GRANT_M1) begin
        s.instr = m1.instr;
        s.addr  = m1.addr;
        s.wdata = m1.wdata;
        s.wstrb = m1.wstrb;
      end else begin
        s.instr = m0.instr;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
        s.wstrb = m0.wstrb;
      end
    end
  end

  assign m0.ready = done && (grant_q == GRANT_M0);
  assign m1.ready = done && (grant_q == GRANT_M1);
  assign m0.rdata = m0.ready ? ret_data : '0;
  assign m1.rdata = m1.ready ? ret_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus reset, contention, abort and stall sequences.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic grant;
  logic timeout_err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if #(.WIDTH(32)) m0_bus ();
  mem_arbiter_if #(.WIDTH(32)) m1_bus ();
  mem_arbiter_if #(.WIDTH(32)) s_bus ();

  mem_arbiter #(
    .WIDTH  (32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic        mst;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] s_rdata;
    logic        exp_grant;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input logic mst);
    return mst ? m1_bus.ready : m0_bus.ready;
  endfunction

  function automatic logic [31:0] rdat(input logic mst);
    return mst ? m1_bus.rdata : m0_bus.rdata;
  endfunction

  task automatic drive(input logic mst, input logic v, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    if (mst) begin
      m1_bus.valid = v; m1_bus.instr = instr; m1_bus.addr = addr;
      m1_bus.wdata = wdata; m1_bus.wstrb = wstrb;
    end else begin
      m0_bus.valid = v; m0_bus.instr = instr; m0_bus.addr = addr;
      m0_bus.wdata = wdata; m0_bus.wstrb = wstrb;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_bus.ready = 1'b0;
    s_bus.rdata = 32'h0;
  endtask

  initial begin
    vec_t v;
    logic exp_g;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 3, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 4'b0011, 1, 32'h0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 0, 32'h0000_0013, 1'b0, 32'h0000_0013};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 4'b0000, 2, 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0102_0304, 4'b1111, 0, 32'h0, 1'b0, 32'h0};

    rst = 1'b1;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    chk("reset_s_valid", 32'(s_bus.valid), 32'h0);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_m0_ready", 32'(m0_bus.ready), 32'h0);
    chk("reset_m1_ready", 32'(m1_bus.ready), 32'h0);
    chk("reset_timeout_err", 32'(timeout_err), 32'h0);
    chk("reset_s_addr", s_bus.addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single-master transactions from the table.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      drive(v.mst, 1'b1, v.instr, v.addr, v.wdata, v.wstrb);
      #1;
      chk("vec_idle_s_valid", 32'(s_bus.valid), 32'h0);
      @(negedge clk);
      chk("vec_busy_s_valid", 32'(s_bus.valid), 32'h1);
      chk("vec_grant", 32'(grant), 32'(v.exp_grant));
      chk("vec_s_instr", 32'(s_bus.instr), 32'(v.instr));
      chk("vec_s_addr", s_bus.addr, v.addr);
      chk("vec_s_wdata", s_bus.wdata, v.wdata);
      chk("vec_s_wstrb", 32'(s_bus.wstrb), 32'(v.wstrb));
      for (int d = 0; d < v.delay; d++) begin
        chk("vec_wait_ready", 32'(rdy(v.mst)), 32'h0);
        chk("vec_wait_other_ready", 32'(rdy(~v.mst)), 32'h0);
        @(negedge clk);
      end
      s_bus.ready = 1'b1;
      s_bus.rdata = v.s_rdata;
      #1;
      chk("vec_ready", 32'(rdy(v.mst)), 32'h1);
      chk("vec_rdata", rdat(v.mst), v.exp_rdata);
      chk("vec_other_ready", 32'(rdy(~v.mst)), 32'h0);
      chk("vec_other_rdata", rdat(~v.mst), 32'h0);
      @(negedge clk);
      idle_all();
      #1;
      chk("vec_after_s_valid", 32'(s_bus.valid), 32'h0);
      chk("vec_after_ready", 32'(rdy(v.mst)), 32'h0);
      @(negedge clk);
    end

    // Reset mid-BUSY; last completion was m0, so only a proper reset gives m0 the next tie.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstmid_busy_s_valid", 32'(s_bus.valid), 32'h1);
    chk("rstmid_busy_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    s_bus.ready = 1'b1;
    #1;
    chk("rstmid_s_valid_async", 32'(s_bus.valid), 32'h0);
    chk("rstmid_grant", 32'(grant), 32'h0);
    chk("rstmid_m1_ready", 32'(m1_bus.ready), 32'h0);
    chk("rstmid_s_addr", s_bus.addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
    #1;
    chk("cont_idle0_s_valid", 32'(s_bus.valid), 32'h0);

    // Continuous contention with s_ready held high: alternate grants, one idle gap each.
    for (int i = 0; i < 5; i++) begin
      exp_g = (i % 2 == 1);
      @(negedge clk);
      chk("cont_busy_s_valid", 32'(s_bus.valid), 32'h1);
      chk("cont_grant", 32'(grant), 32'(exp_g));
      chk("cont_ready", 32'(rdy(exp_g)), 32'h1);
      chk("cont_other_ready", 32'(rdy(~exp_g)), 32'h0);
      @(negedge clk);
      chk("cont_gap_s_valid", 32'(s_bus.valid), 32'h0);
      chk("cont_gap_ready", 32'(m0_bus.ready | m1_bus.ready), 32'h0);
      if (i == 4) idle_all();
    end

    // Master abort: m1 drops valid in BUSY; last_grant stays m0 so the tie goes to m1.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    @(negedge clk);
    chk("abort_busy_grant", 32'(grant), 32'h1);
    chk("abort_busy_s_valid", 32'(s_bus.valid), 32'h1);
    m1_bus.valid = 1'b0;
    #1;
    chk("abort_m1_ready", 32'(m1_bus.ready), 32'h0);
    @(negedge clk);
    chk("abort_idle_s_valid", 32'(s_bus.valid), 32'h0);
    chk("abort_idle_m1_ready", 32'(m1_bus.ready), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0064, 32'h0, 4'h0);
    @(negedge clk);
    chk("abort_tie_grant", 32'(grant), 32'h1);
    s_bus.ready = 1'b1;
    s_bus.rdata = 32'h7777_0001;
    #1;
    chk("abort_tie_m1_ready", 32'(m1_bus.ready), 32'h1);
    chk("abort_tie_m1_rdata", m1_bus.rdata, 32'h7777_0001);
    @(negedge clk);
    idle_all();
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog expiry on the 4th stalled BUSY cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 4'h0);
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      chk("wd_wait_ready", 32'(m0_bus.ready), 32'h0);
      chk("wd_wait_err", 32'(timeout_err), 32'h0);
      @(negedge clk);
    end
    chk("wd_expire_ready", 32'(m0_bus.ready), 32'h1);
    chk("wd_expire_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
    chk("wd_expire_err", 32'(timeout_err), 32'h1);
    @(negedge clk);
    chk("wd_after_err", 32'(timeout_err), 32'h0);
    chk("wd_after_s_valid", 32'(s_bus.valid), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0074, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0078, 32'h0, 4'h0);
    @(negedge clk);
    chk("wd_tie_grant", 32'(grant), 32'h1);
    s_bus.ready = 1'b1;
    @(negedge clk);
    idle_all();
    @(negedge clk);

    // s_ready on the expiry cycle wins over the watchdog.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_007C, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    s_bus.ready = 1'b1;
    s_bus.rdata = 32'h0000_0055;
    #1;
    chk("wd_race_ready", 32'(m0_bus.ready), 32'h1);
    chk("wd_race_rdata", m0_bus.rdata, 32'h0000_0055);
    chk("wd_race_err", 32'(timeout_err), 32'h0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
`else
    // Without the watchdog a stalled slave holds BUSY indefinitely.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 4'h0);
    for (int c = 0; c < 21; c++) @(negedge clk);
    chk("stall_s_valid", 32'(s_bus.valid), 32'h1);
    chk("stall_m0_ready", 32'(m0_bus.ready), 32'h0);
    chk("stall_err", 32'(timeout_err), 32'h0);
    s_bus.ready = 1'b1;
    s_bus.rdata = 32'h0000_0055;
    #1;
    chk("stall_done_ready", 32'(m0_bus.ready), 32'h1);
    chk("stall_done_rdata", m0_bus.rdata, 32'h0000_0055);
    @(negedge clk);
    idle_all();
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master round-robin arbiter that shares the single on-chip RAM port (the 64 kB linked-list memory behind the memory driver) between the PicoRV32 core and a second bus master such as a list-walking accelerator or debug loader. Both upstream ports and the downstream port use the PicoRV32 native memory handshake: `valid`, `instr`, `addr`, `wdata`, `wstrb`, `ready` and `rdata`. The block sits between the masters and the memory driver. It serialises accesses, forces a one-cycle `valid` gap between transactions so the driver's `ready` clears, and can optionally recover from a hung slave.

## Interface
Parameters:
- `WIDTH`, 32, data/address width.
- `TIMEOUT`, 16, BUSY cycles before the watchdog aborts a transaction. Minimum 2. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_valid`, `m0_instr`  in  1 each  master 0 (CPU) request.
- `m0_addr`, `m0_wdata`  in  WIDTH each  master 0 address and write data.
- `m0_wstrb`  in  4  master 0 byte strobes.
- `m0_ready`  out  1  master 0 transaction done.
- `m0_rdata`  out  WIDTH  master 0 read data.
- `m1_*`  identical set for master 1.
- `s_valid`, `s_instr`  out  1 each  request to the memory driver.
- `s_addr`, `s_wdata`  out  WIDTH each  address and write data to the memory driver.
- `s_wstrb`  out  4  byte strobes to the memory driver.
- `s_ready`  in  1  memory driver done.
- `s_rdata`  in  WIDTH  memory driver read data.
- `grant`  out  1  index of the current or last granted master.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- State machine has two states: IDLE and BUSY.
- **IDLE**
  - `s_valid`=0.
  - If any `mN_valid`=1, select the winner, register it in `grant`, and go to BUSY on the next edge.
- **Arbitration**
  - A single requester wins outright.
  - If both request, the winner is the master ≠ `last_grant`.
  - `last_grant` updates when a transaction completes.
- **BUSY**
  - `s_valid`=1.
  - `s_instr`, `s_addr`, `s_wdata` and `s_wstrb` are a combinational mux of the granted master's inputs. Masters hold these inputs stable per protocol.
- **Completion**
  - Completion occurs in a BUSY cycle with `s_ready`=1.
  - In that same cycle: granted `mN_ready`=1 and `mN_rdata`=`s_rdata`.
  - Next state is IDLE.
- Non-granted master: `ready`=0 and `rdata`=0 at all times.
- **Abort by master:** if the granted master drops `valid` while in BUSY, return to IDLE with no `ready` and no `last_grant` update.
- **Writes:** `s_wstrb`≠0 is passed through unchanged. Completion is again signalled by `s_ready`.

## Timing
- **Reset values:** state=IDLE, `grant`=0, `last_grant`=1 (so m0 wins the first tie). All outputs are 0.
- **Reset mid-transaction:** the in-flight access is dropped and `s_valid` falls asynchronously.
- **Latency:** `mN_valid` rising in cycle N gives `s_valid` in cycle N+1. `mN_ready` is combinational with `s_ready`, i.e. zero added cycles on the return path.
- **Transaction spacing:** at least one IDLE cycle with `s_valid`=0 between any two transactions, including back-to-back requests from the same master.
- **Contention:** with both masters continuously requesting, grants alternate m0, m1, m0, ….
- **Simultaneous events:**
  - `s_ready` and master `valid` drop in the same cycle: treated as a completion.
  - `s_ready` and watchdog expiry in the same cycle: `s_ready` wins and there is no error.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - A watchdog counter clears on entry to BUSY and increments on each BUSY cycle without `s_ready`.
  - On the TIMEOUT-th BUSY cycle without `s_ready`, all of the following happen in that cycle:
    - granted `mN_ready`=1;
    - `mN_rdata`=`MEM_ARB_TIMEOUT_RDATA` (32'hDEAD_BEEF);
    - `timeout_err`=1 for one cycle;
    - `last_grant` updates.
  - Next state is IDLE.
- **Undefined:** no counter is built, `timeout_err` is tied 0, and BUSY waits indefinitely for `s_ready`.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (`ARB_IDLE`, `ARB_BUSY`);
  - grant constants `GRANT_M0`=0 and `GRANT_M1`=1;
  - `MEM_ARB_TIMEOUT_RDATA`.
- One sub-module, `mem_arb_watchdog`:
  - ports: `clk`, `rst`, `clear`, `run`, `expire`;
  - counter width `$clog2(TIMEOUT)`;
  - instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Reset:** assert `rst` mid-BUSY → `s_valid` falls the same cycle; all outputs 0; the next tie goes to m0.
- **m0 only:** m0 read at 0x0000_0010, with `s_ready` 3 cycles after `s_valid` and `s_rdata`=0x1234_5678 → `m0_ready` in the `s_ready` cycle with `m0_rdata`=0x1234_5678; `m1_ready`=0 throughout.
- **Contention:** m0 and m1 request continuously → grant order m0, m1, m0, m1, with exactly one `s_valid`=0 cycle between transactions.
- **Write passthrough:** m1 write, `wstrb`=4'b0011, `wdata`=0xCAFE_F00D, `addr`=0x20 → `s_*` mirror these exactly; `m1_ready` follows `s_ready`.
- **Watchdog (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=4):**
  - `s_ready` never asserted → on the 4th BUSY cycle, `m0_ready`=1, `m0_rdata`=0xDEAD_BEEF, and a one-cycle `timeout_err` pulse; the next contested grant goes to m1.
  - `s_ready` arriving on the 4th BUSY cycle → normal completion with no error.
- **Master abort:** m1 drops `valid` in BUSY before `s_ready` → IDLE next cycle; no `m1_ready`; `last_grant` unchanged.
